// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO slice.
// Holds the default word/address widths, the derived depth and count width,
// and the pointer-width helper used by the FIFO, its interface and its tests.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  // Pointers carry one extra wrap bit above the array address.
  function automatic int fifo_ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  localparam int DEPTH_DEF = fifo_depth(ADDR_W_DEF);
  localparam int CNT_W_DEF = fifo_ptr_w(ADDR_W_DEF);

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle between a producer/consumer and sync_fifo_param.
//   wr_en_in, wr_data_in, rd_en_in         : requests into the FIFO
//   rd_data_out, rd_valid                  : read data path
//   full, empty, almost_full, almost_empty : registered status flags
//   count                                  : occupancy, 0..DEPTH
//   overflow, underflow                    : one-cycle error pulses
// Modport slave is the FIFO side, master is the user side.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              wr_en_in;
  logic [DATA_W-1:0] wr_data_in;
  logic              rd_en_in;
  logic [DATA_W-1:0] rd_data_out;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en_in, wr_data_in, rd_en_in,
    input  rd_data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en_in, wr_data_in, rd_en_in,
    output rd_data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_sdpram.sv
// Simple dual-port RAM, one clock: one write port, one registered read port.
// Array contents are never reset; only the read data register is.
//   clk, rst           : clock, asynchronous active-high reset
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr       : read request; o_rdata updates the edge after i_re
//   o_rdata            : read data, holds when i_re is low
module sync_sdpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count and overflow/underflow pulses.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : sync_fifo_param_if.slave (requests in, data/status out)
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word fall-through:
// the RAM read register acts as a prefetch head register, rd_data_out shows
// the head word and rd_en_in pops it. Default build is standard mode with a
// 1-cycle registered read and a rd_valid pulse per accepted read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic clk,
  input  logic rst,
  sync_fifo_param_if.slave bus
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam int PTR_W = fifo_ptr_w(ADDR_W);
  localparam int CNT_W = PTR_W;

  if (!((AEMPTY_TH < AFULL_TH) && (AFULL_TH <= DEPTH))) begin : g_bad_thresholds
    $error("sync_fifo_param: thresholds need AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_full, r_empty, r_afull, r_aempty;
  logic              r_overflow, r_underflow;
  logic              w_wr_acc, w_rd_acc, w_ram_re, w_underflow;
  logic [DATA_W-1:0] w_ram_q;

  assign w_wr_acc = bus.wr_en_in & ~r_full;

`ifdef SYNC_FIFO_FWFT_EN
  // The RAM read register holds the head word. The RAM itself is non-empty
  // when the pointers differ; refill the head whenever it is free or popped.
  logic r_head_valid;
  logic w_ram_has;

  assign w_ram_has   = (r_wr_ptr != r_rd_ptr);
  assign w_rd_acc    = bus.rd_en_in & r_head_valid;
  assign w_ram_re    = w_ram_has & (~r_head_valid | w_rd_acc);
  // A pop with no head word present (including a word still in flight from
  // the RAM) is reported as an underflow rather than silently dropped.
  assign w_underflow = bus.rd_en_in & ~r_head_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_head_valid <= 1'b0;
    else if (w_ram_re) r_head_valid <= 1'b1;
    else if (w_rd_acc) r_head_valid <= 1'b0;
  end

  assign bus.rd_valid = ~r_empty;
`else
  logic r_rd_valid;

  assign w_rd_acc    = bus.rd_en_in & ~r_empty;
  assign w_ram_re    = w_rd_acc;
  assign w_underflow = bus.rd_en_in & r_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_valid <= 1'b0;
    else     r_rd_valid <= w_rd_acc;
  end

  assign bus.rd_valid = r_rd_valid;
`endif

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_wr_acc && w_rd_acc) w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_ram_re) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_nxt;
      // Flags come from the next count so they line up with count itself.
      r_full      <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty     <= (w_count_nxt == '0);
      r_afull     <= (w_count_nxt >= CNT_W'(AFULL_TH));
      r_aempty    <= (w_count_nxt <= CNT_W'(AEMPTY_TH));
      r_overflow  <= bus.wr_en_in & r_full;
      r_underflow <= w_underflow;
    end
  end

  sync_sdpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (bus.wr_data_in),
    .i_re    (w_ram_re),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_ram_q)
  );

  assign bus.rd_data_out  = w_ram_q;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_afull;
  assign bus.almost_empty = r_aempty;
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (standard mode, DATA_W=8, ADDR_W=4,
// AFULL_TH=12, AEMPTY_TH=2). A queue holds words the model expects to come
// out; each accepted write pushes, each accepted read pops and compares.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sync_fifo_param_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  sync_fifo_param #(
    .DATA_W(8), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_errors = 0;
  int        m_count  = 0;
  logic [7:0] m_last  = 8'h00;
  logic [7:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from its own state.
  task automatic step(input logic wr, input logic [7:0] wd, input logic rd);
    logic wacc, racc, ov, un;
    logic [7:0] exp_d;
    bus.wr_en_in   = wr;
    bus.wr_data_in = wd;
    bus.rd_en_in   = rd;
    ov   = wr && (m_count == 16);
    un   = rd && (m_count == 0);
    wacc = wr && !ov;
    racc = rd && !un;
    if (wacc) sb.push_back(wd);
    @(posedge clk);
    #1;
    exp_d = m_last;
    if (racc) exp_d = sb.pop_front();
    m_last  = exp_d;
    m_count = m_count + int'(wacc) - int'(racc);
    check("count", 32'(bus.count), 32'(m_count));
    check("flags",
          {25'd0, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
           bus.overflow, bus.underflow, bus.rd_valid},
          {25'd0, m_count == 16, m_count == 0, m_count >= 12, m_count <= 2,
           ov, un, racc});
    check("rd_data", 32'(bus.rd_data_out), 32'(exp_d));
    bus.wr_en_in = 1'b0;
    bus.rd_en_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
    check({tag, "_flags"},
          {25'd0, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
           bus.overflow, bus.underflow, bus.rd_valid},
          32'b0101000);
    check({tag, "_rd_data"}, 32'(bus.rd_data_out), 32'd0);
  endtask

  initial begin
    bus.wr_en_in   = 1'b0;
    bus.wr_data_in = 8'h00;
    bus.rd_en_in   = 1'b0;

    // Reset state
    #12;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Fill with 0x00..0x0F, then a write while full
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);

    // Drain in order; 0xAA must never appear
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

    // Read on empty: underflow, data holds 0x0F
    step(1'b0, 8'h00, 1'b1);

    // Simultaneous read+write while full, then while empty
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    step(1'b1, 8'hBB, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hCC, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // 40 interleaved operations crossing the pointer wrap twice
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h40 + i), (i % 4) != 0);
    while (m_count > 0) step(1'b0, 8'h00, 1'b1);

    // Reset in the middle of a burst at count 7
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h90 + i), 1'b0);
    bus.wr_en_in   = 1'b1;
    bus.wr_data_in = 8'h97;
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    bus.wr_en_in = 1'b0;
    #2;
    rst = 1'b0;
    sb.delete();
    m_count = 0;
    m_last  = 8'h00;

    // New data after reset comes back first
    step(1'b1, 8'h5C, 1'b0);
    step(1'b1, 8'h5D, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
